// File: rtl/dehaze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dehaze_pkg
// Description : Shared constants for the dehaze pipeline (FSM encoding and
//               atmospheric-light defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package dehaze_pkg;

    localparam logic [7:0] C_A_INIT_DEF = 8'd200;
    localparam logic [7:0] C_A_MAX_DEF  = 8'd240;
    localparam logic [7:0] C_T_MIN_DEF  = 8'd26;

    localparam int unsigned C_ST_W = 2;
    localparam logic [C_ST_W-1:0] S_WAIT_VS = 2'd0;
    localparam logic [C_ST_W-1:0] S_ACCUM   = 2'd1;
    localparam logic [C_ST_W-1:0] S_UPDATE  = 2'd2;
    localparam logic [C_ST_W-1:0] S_FLOOR   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dark_min3.sv
`default_nettype none
// ============================================================================
// Module      : dark_min3
// Description : Combinational per-pixel dark value, min(R,G,B).
// Revision    : 1.0 - initial release
// ============================================================================
module dark_min3 (
    input  logic [23:0] rgb,
    output logic [7:0]  dark
);

    logic [7:0] w_min_rg;

    assign w_min_rg = (rgb[23:16] < rgb[15:8]) ? rgb[23:16] : rgb[15:8];
    assign dark     = (w_min_rg < rgb[7:0]) ? w_min_rg : rgb[7:0];

endmodule
`default_nettype wire

// File: rtl/atmos_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : atmos_light_ctrl
// Description : Per-frame atmospheric light estimate (max dark value, IIR
//               smoothed and clamped) plus the a*t floor for recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module atmos_light_ctrl
    import dehaze_pkg::*;
#(
    parameter logic [7:0] A_INIT = C_A_INIT_DEF,
    parameter logic [7:0] A_MAX  = C_A_MAX_DEF,
    parameter logic [7:0] T_MIN  = C_T_MIN_DEF
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic [23:0] i_rgb,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic        cfg_freeze,
    output logic [7:0]  o_a,
    output logic [7:0]  o_at_floor,
    output logic        o_a_valid,
    output logic [15:0] o_frame_cnt
);

    localparam logic [15:0] C_FLOOR_PROD_INIT = 16'(A_INIT) * 16'(T_MIN);
    localparam logic [7:0]  C_FLOOR_INIT      = C_FLOOR_PROD_INIT[15:8];

    logic [C_ST_W-1:0] r_state;
    logic [C_ST_W-1:0] w_state_nxt;
    logic              r_vs_d;
    logic [7:0]        r_frame_max;
    logic              r_pix_seen;
    logic [7:0]        r_snap_max;
    logic              r_snap_seen;

    logic              w_vs_rise;
    logic [7:0]        w_dark;
    logic [7:0]        w_acc_max;
    logic [9:0]        w_blend_sum;
    logic [7:0]        w_a_raw;
    logic [7:0]        w_a_new;
    logic [15:0]       w_floor_prod;

    dark_min3 u_dark_min3 (
        .rgb  (i_rgb),
        .dark (w_dark)
    );

    assign w_vs_rise    = i_vsync & ~r_vs_d;
    assign w_acc_max    = (w_dark > r_frame_max) ? w_dark : r_frame_max;
    assign w_blend_sum  = 10'(o_a) * 10'd3 + 10'(r_snap_max) + 10'd2;
    assign w_a_raw      = o_a_valid ? w_blend_sum[9:2] : r_snap_max;
    assign w_a_new      = (w_a_raw > A_MAX) ? A_MAX : w_a_raw;
    assign w_floor_prod = 16'(o_a) * 16'(T_MIN);

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT_VS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Edges arriving in S_UPDATE/S_FLOOR are dropped, not queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_VS: if (w_vs_rise) w_state_nxt = S_ACCUM;
            S_ACCUM:   if (w_vs_rise) w_state_nxt = S_UPDATE;
            S_UPDATE:  w_state_nxt = S_FLOOR;
            S_FLOOR:   w_state_nxt = S_ACCUM;
            default:   w_state_nxt = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d      <= 1'b0;
            r_frame_max <= 8'd0;
            r_pix_seen  <= 1'b0;
            r_snap_max  <= 8'd0;
            r_snap_seen <= 1'b0;
            o_a         <= A_INIT;
            o_at_floor  <= C_FLOOR_INIT;
            o_a_valid   <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            r_vs_d <= i_vsync;
            if (r_state == S_ACCUM && w_vs_rise) begin
                r_snap_max  <= r_frame_max;
                r_snap_seen <= r_pix_seen;
                r_frame_max <= 8'd0;
                r_pix_seen  <= 1'b0;
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end else if (r_state != S_WAIT_VS && i_de) begin
                r_frame_max <= w_acc_max;
                r_pix_seen  <= 1'b1;
            end
            if (r_state == S_UPDATE && r_snap_seen && !cfg_freeze) begin
                o_a       <= w_a_new;
                o_a_valid <= 1'b1;
            end
            if (r_state == S_FLOOR) begin
                o_at_floor <= w_floor_prod[15:8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atmos_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_atmos_light_ctrl
// Description : Directed self-checking bench for atmos_light_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atmos_light_ctrl;

    logic        pixelclk;
    logic        reset_n;
    logic [23:0] i_rgb;
    logic        i_vsync;
    logic        i_de;
    logic        cfg_freeze;
    logic [7:0]  o_a;
    logic [7:0]  o_at_floor;
    logic        o_a_valid;
    logic [15:0] o_frame_cnt;

    int n_cmp;
    int n_err;

    atmos_light_ctrl u_dut (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .i_rgb       (i_rgb),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .cfg_freeze  (cfg_freeze),
        .o_a         (o_a),
        .o_at_floor  (o_at_floor),
        .o_a_valid   (o_a_valid),
        .o_frame_cnt (o_frame_cnt)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pixelclk);
            #1;
        end
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        i_rgb = {r, g, b};
        i_de  = 1'b1;
        tick(1);
        i_de  = 1'b0;
        tick(1);
    endtask

    // Vsync pulse, then wait until both outputs have settled.
    task automatic vs_boundary();
        i_vsync = 1'b1;
        tick(1);
        i_vsync = 1'b0;
        tick(2);
    endtask

    task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] fl,
                             input logic v, input logic [15:0] cnt);
        chk({tag, ".a"},     16'(o_a),        16'(a));
        chk({tag, ".floor"}, 16'(o_at_floor), 16'(fl));
        chk({tag, ".valid"}, 16'(o_a_valid),  16'(v));
        chk({tag, ".cnt"},   o_frame_cnt,     cnt);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        i_rgb      = 24'd0;
        i_vsync    = 1'b0;
        i_de       = 1'b0;
        cfg_freeze = 1'b0;
        do_reset();

        // Pixels without any vsync edge are ignored.
        pix(8'd250, 8'd250, 8'd250);
        pix(8'd255, 8'd240, 8'd245);
        check_out("rst", 8'd200, 8'd20, 1'b0, 16'd0);

        vs_boundary();
        check_out("first_edge", 8'd200, 8'd20, 1'b0, 16'd0);

        // First measured frame, max dark 240.
        pix(8'd240, 8'd250, 8'd255);
        pix(8'd100, 8'd50, 8'd200);
        vs_boundary();
        check_out("f1", 8'd240, 8'd24, 1'b1, 16'd1);

        // Empty frame.
        vs_boundary();
        check_out("empty", 8'd240, 8'd24, 1'b1, 16'd2);

        // Frozen frame with max 50.
        cfg_freeze = 1'b1;
        pix(8'd50, 8'd60, 8'd70);
        vs_boundary();
        cfg_freeze = 1'b0;
        check_out("freeze", 8'd240, 8'd24, 1'b1, 16'd3);

        // Blend 240 with 100: (720+100+2)>>2 = 205, floor 5330>>8 = 20.
        pix(8'd100, 8'd120, 8'd110);
        vs_boundary();
        check_out("blend100", 8'd205, 8'd20, 1'b1, 16'd4);

        // Asynchronous reset mid-frame.
        pix(8'd200, 8'd200, 8'd200);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_rst", 8'd200, 8'd20, 1'b0, 16'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        pix(8'd255, 8'd255, 8'd255);
        vs_boundary();
        check_out("post_rst_edge", 8'd200, 8'd20, 1'b0, 16'd0);

        // First frame max 200, then 240 -> (600+240+2)>>2 = 210, floor 21.
        pix(8'd200, 8'd210, 8'd220);
        vs_boundary();
        check_out("f200", 8'd200, 8'd20, 1'b1, 16'd1);
        pix(8'd240, 8'd240, 8'd240);
        pix(8'd10, 8'd20, 8'd30);
        vs_boundary();
        check_out("f240", 8'd210, 8'd21, 1'b1, 16'd2);

        // Saturated first frame clamps to A_MAX.
        do_reset();
        vs_boundary();
        pix(8'd255, 8'd255, 8'd255);
        pix(8'd255, 8'd255, 8'd255);
        vs_boundary();
        check_out("clamp", 8'd240, 8'd24, 1'b1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/atmos_light_ctrl.md
ATMOS_LIGHT_CTRL -- requirements
Module: atmos_light_ctrl

Interface
REQ-001 Parameter A_INIT, default 8'd200, value of a after reset until the first completed frame.
REQ-002 Parameter A_MAX, default 8'd240, upper clamp on a.
REQ-003 Parameter T_MIN, default 8'd26, minimum transmission in units of 1/256, used for at_floor.
REQ-004 pixelclk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_rgb  in  24  pixel: R=[23:16], G=[15:8], B=[7:0].
REQ-007 i_vsync  in  1  active-high frame sync; its rising edge is the frame boundary.
REQ-008 i_de  in  1  active-pixel qualifier.
REQ-009 cfg_freeze  in  1  when high, a and at_floor hold their values.
REQ-010 o_a  out  8  atmospheric light, frame-stable; drives the recovery stage's a input.
REQ-011 o_at_floor  out  8  floor for the a*t product, for clamping the recovery stage's at input.
REQ-012 o_a_valid  out  1  high once a has been updated from at least one measured frame.
REQ-013 o_frame_cnt  out  16  count of completed frames, wraps at 16'hFFFF -> 0.

Function
REQ-014 The block shall compute the pixel dark value as min(R,G,B) whenever i_de=1.
REQ-015 In S_ACCUM, frame_max shall register max(frame_max, dark) on each i_de=1 cycle; pix_seen shall set to 1 on the first such cycle.
REQ-016 FSM states: S_WAIT_VS, S_ACCUM, S_UPDATE, S_FLOOR.
REQ-017 S_WAIT_VS -> S_ACCUM on an i_vsync rising edge (edge detected against a registered copy of i_vsync); pixels seen before that edge shall be ignored.
REQ-018 S_ACCUM -> S_UPDATE on an i_vsync rising edge; on that same edge the block shall latch frame_max/pix_seen into snapshot registers, clear frame_max to 0 and pix_seen to 0, and increment o_frame_cnt.
REQ-019 S_UPDATE -> S_FLOOR after exactly 1 cycle; S_FLOOR -> S_ACCUM after exactly 1 cycle; pixels with i_de=1 during S_UPDATE or S_FLOOR shall still be accumulated into the new frame.
REQ-020 In S_UPDATE, if snapshot pix_seen=1 and cfg_freeze=0: when o_a_valid=0, a_new=snapshot max; otherwise a_new=(3*o_a + snapshot max + 2)>>2, using a 10-bit intermediate; then a_new shall be clamped to A_MAX, written to o_a, and o_a_valid shall be set.
REQ-021 In S_UPDATE, if snapshot pix_seen=0 (empty frame) or cfg_freeze=1, o_a and o_a_valid shall be unchanged.
REQ-022 In S_FLOOR, o_at_floor shall be set to (o_a*T_MIN)>>8 using a 16-bit product; it shall be evaluated every frame, including frozen or empty frames.
REQ-023 o_a and o_at_floor shall change only in the 2 cycles following a frame boundary; total latency is vsync edge + 2 cycles.
REQ-024 An i_vsync rising edge during S_UPDATE or S_FLOOR shall be treated as a frame boundary only after the block returns to S_ACCUM; edges are not queued, and that frame's pixels merge into the following frame.

Reset
REQ-025 Reset shall give: state=S_WAIT_VS, o_a=A_INIT, o_at_floor=(A_INIT*T_MIN)>>8 (constant), o_a_valid=0, o_frame_cnt=0, frame_max=0, pix_seen=0, registered i_vsync=0.
REQ-026 Reset asserted mid-frame or mid-update shall abort immediately with no partial update; after release, measurement restarts at the next vsync rising edge.

Structure
REQ-027 The FSM state encoding and the default values of A_INIT, A_MAX and T_MIN shall live in a shared dehaze package.
REQ-028 min3 shall be a sub-module named dark_min3: combinational, 24-bit in, 8-bit out, reusable by the dark-channel stage.

Verification
REQ-029 Reset, then hold i_vsync=0 with pixels driven -> o_a=200, o_at_floor=20, o_a_valid=0, o_frame_cnt=0.
REQ-030 First frame has maximum dark value 240 -> 2 cycles after the closing vsync edge: o_a=240, o_a_valid=1, o_at_floor=24, o_frame_cnt=1.
REQ-031 With o_a=200 and next frame max 240 -> o_a=210, o_at_floor=21.
REQ-032 First frame is all pixels RGB=(255,255,255) -> dark=255, o_a clamped to 240.
REQ-033 Frame with i_de never asserted, or cfg_freeze=1 with frame max 50 -> o_a unchanged, o_frame_cnt still increments.
REQ-034 reset_n pulsed low mid-frame -> all outputs return to reset values; the first post-reset frame is ignored until a vsync edge has been seen.
